chip8_seq: RTL and testbench

- Instruction sequencer for the CHIP-8 core; owns the program counter and the 16-level call stack.
- Fetches each 16-bit big-endian opcode from byte-wide program RAM.
- Presents the opcode to the registered opcode decoder and waits for its result.
- Hands the decoded operation to the execute unit with a start/done handshake, then applies the PC update returned by the execute unit.

---
 rtl/chip8_seq.sv | 184 ++++++++++++++++++
 tb/tb_chip8_seq.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_seq.sv
// CHIP-8 instruction sequencer: fetches big-endian opcodes, hands them to decode/execute,
// and owns the program counter and the return-address stack.
module chip8_seq #(
    parameter logic [11:0] PC_RESET    = 12'h200,
    parameter int unsigned STACK_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_i,
    output logic        mem_rd_o,
    output logic [11:0] mem_addr_o,
    input  logic [7:0]  mem_rdata_i,
    output logic [15:0] instr_o,
    input  logic [5:0]  dec_op_i,
    output logic        exec_start_o,
    input  logic        exec_done_i,
    input  logic [2:0]  pc_op_i,
    input  logic [11:0] pc_target_i,
    output logic [11:0] pc_o,
    output logic [4:0]  sp_o,
    output logic        busy_o,
    output logic        fault_o,
    output logic [1:0]  fault_code_o
);

    localparam int unsigned SpW   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [4:0]  SpMax = 5'(STACK_DEPTH);

    localparam logic [2:0] PcNext = 3'd0;
    localparam logic [2:0] PcSkip = 3'd1;
    localparam logic [2:0] PcJump = 3'd2;
    localparam logic [2:0] PcCall = 3'd3;
    localparam logic [2:0] PcRet  = 3'd4;

    localparam logic [1:0] FaultIllegal   = 2'd1;
    localparam logic [1:0] FaultOverflow  = 2'd2;
    localparam logic [1:0] FaultUnderflow = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StFetchHi,
        StFetchLo,
        StLatch,
        StDecode,
        StDispatch,
        StExec,
        StHalt
    } state_e;

    state_e      state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [4:0]  sp_q, sp_d;
    logic [15:0] instr_q, instr_d;
    logic        fault_q, fault_d;
    logic [1:0]  code_q, code_d;

    logic        push;
    logic [11:0] pc_plus2;
    logic [4:0]  sp_m1;
    logic [11:0] stack_q [STACK_DEPTH];

    assign pc_plus2 = pc_q + 12'd2;
    assign sp_m1    = sp_q - 5'd1;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        sp_d         = sp_q;
        instr_d      = instr_q;
        fault_d      = fault_q;
        code_d       = code_q;
        push         = 1'b0;
        mem_rd_o     = 1'b0;
        mem_addr_o   = 12'h000;
        exec_start_o = 1'b0;

        case (state_q)
            StIdle: begin
                if (run_i) begin
                    state_d = StFetchHi;
                end
            end
            StFetchHi: begin
                mem_rd_o   = 1'b1;
                mem_addr_o = pc_q;
                state_d    = StFetchLo;
            end
            StFetchLo: begin
                instr_d[15:8] = mem_rdata_i;
                mem_rd_o      = 1'b1;
                mem_addr_o    = pc_q + 12'd1;
                state_d       = StLatch;
            end
            StLatch: begin
                instr_d[7:0] = mem_rdata_i;
                state_d      = StDecode;
            end
            StDecode: begin
                // Decoder output is registered; give it one cycle to settle.
                state_d = StDispatch;
            end
            StDispatch: begin
                if (dec_op_i == 6'd0) begin
                    fault_d = 1'b1;
                    code_d  = FaultIllegal;
                    state_d = StHalt;
                end else begin
                    exec_start_o = 1'b1;
                    state_d      = StExec;
                end
            end
            StExec: begin
                if (exec_done_i) begin
                    state_d = run_i ? StFetchHi : StIdle;
                    case (pc_op_i)
                        PcSkip: pc_d = pc_q + 12'd4;
                        PcJump: pc_d = pc_target_i;
                        PcCall: begin
                            if (sp_q == SpMax) begin
                                fault_d = 1'b1;
                                code_d  = FaultOverflow;
                                state_d = StHalt;
                            end else begin
                                push = 1'b1;
                                sp_d = sp_q + 5'd1;
                                pc_d = pc_target_i;
                            end
                        end
                        PcRet: begin
                            if (sp_q == 5'd0) begin
                                fault_d = 1'b1;
                                code_d  = FaultUnderflow;
                                state_d = StHalt;
                            end else begin
                                sp_d = sp_m1;
                                pc_d = stack_q[sp_m1[SpW-1:0]];
                            end
                        end
                        default: pc_d = pc_plus2;
                    endcase
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= PC_RESET;
            sp_q    <= 5'd0;
            instr_q <= 16'h0000;
            fault_q <= 1'b0;
            code_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
            code_q  <= code_d;
        end
    end

    // Return-address storage is deliberately left unreset; sp alone defines validity.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_q[sp_q[SpW-1:0]] <= pc_plus2;
        end
    end

    assign instr_o      = instr_q;
    assign pc_o         = pc_q;
    assign sp_o         = sp_q;
    assign busy_o       = (state_q != StIdle) && (state_q != StHalt);
    assign fault_o      = fault_q;
    assign fault_code_o = code_q;

endmodule

// File: tb/tb_chip8_seq.sv
// Directed plus randomized bench for chip8_seq with a queue-based PC/stack reference model.
module tb_chip8_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        mem_rd;
    logic [11:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic [15:0] instr;
    logic [5:0]  dec_op;
    logic        exec_start;
    logic        exec_done;
    logic [2:0]  pc_op;
    logic [11:0] pc_target;
    logic [11:0] pc;
    logic [4:0]  sp;
    logic        busy;
    logic        fault;
    logic [1:0]  fault_code;

    chip8_seq #(
        .PC_RESET    (12'h200),
        .STACK_DEPTH (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run_i        (run),
        .mem_rd_o     (mem_rd),
        .mem_addr_o   (mem_addr),
        .mem_rdata_i  (mem_rdata),
        .instr_o      (instr),
        .dec_op_i     (dec_op),
        .exec_start_o (exec_start),
        .exec_done_i  (exec_done),
        .pc_op_i      (pc_op),
        .pc_target_i  (pc_target),
        .pc_o         (pc),
        .sp_o         (sp),
        .busy_o       (busy),
        .fault_o      (fault),
        .fault_code_o (fault_code)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [4096];
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= ram[mem_addr];
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: PC plus a plain queue used as the return stack.
    logic [11:0] m_pc;
    logic [11:0] m_stk[$];
    logic        m_fault;
    logic [1:0]  m_code;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 12'h200;
        m_stk.delete();
        m_fault = 1'b0;
        m_code  = 2'd0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        run       = 1'b0;
        exec_done = 1'b0;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_pc"}, pc, m_pc);
        chk({tag, "_sp"}, sp, m_stk.size());
        chk({tag, "_fault"}, fault, m_fault);
        chk({tag, "_code"}, fault_code, m_code);
    endtask

    task automatic model_exec(input logic [2:0] op, input logic [11:0] tgt);
        logic [11:0] ret;
        case (op)
            3'd1: m_pc = m_pc + 12'd4;
            3'd2: m_pc = tgt;
            3'd3: begin
                if (m_stk.size() == 16) begin
                    m_fault = 1'b1;
                    m_code  = 2'd2;
                end else begin
                    ret = m_pc + 12'd2;
                    m_stk.push_back(ret);
                    m_pc = tgt;
                end
            end
            3'd4: begin
                if (m_stk.size() == 0) begin
                    m_fault = 1'b1;
                    m_code  = 2'd3;
                end else begin
                    m_pc = m_stk.pop_back();
                end
            end
            default: m_pc = m_pc + 12'd2;
        endcase
    endtask

    // Entered with the DUT in its first fetch cycle; walks one full instruction.
    task automatic exec_instr(input logic [5:0] dec, input logic [2:0] op, input logic [11:0] tgt,
                              input int wcyc, input logic run_after);
        logic [11:0] a1;
        logic [15:0] exp_instr;
        a1        = m_pc + 12'd1;
        exp_instr = {ram[m_pc], ram[a1]};
        dec_op    = dec;
        chk("fhi_rd", mem_rd, 1'b1);
        chk("fhi_addr", mem_addr, m_pc);
        chk("fhi_busy", busy, 1'b1);
        tick();
        chk("flo_rd", mem_rd, 1'b1);
        chk("flo_addr", mem_addr, a1);
        // Stray completion outside EXEC must be ignored.
        exec_done = 1'b1;
        pc_op     = 3'd2;
        pc_target = 12'($urandom);
        tick();
        exec_done = 1'b0;
        chk("latch_rd", mem_rd, 1'b0);
        tick();
        chk("instr", instr, exp_instr);
        chk("dec_pc", pc, m_pc);
        tick();
        chk("exec_start", exec_start, dec != 6'd0);
        if (dec == 6'd0) begin
            tick();
            m_fault = 1'b1;
            m_code  = 2'd1;
            chk_state("illegal");
            chk("illegal_busy", busy, 1'b0);
            return;
        end
        tick();
        chk("exec_start_low", exec_start, 1'b0);
        chk("exec_busy", busy, 1'b1);
        run = run_after;
        repeat (wcyc) tick();
        exec_done = 1'b1;
        pc_op     = op;
        pc_target = tgt;
        tick();
        exec_done = 1'b0;
        model_exec(op, tgt);
        chk_state("exec");
        if (m_fault) chk("halt_busy", busy, 1'b0);
        else if (run_after) chk("next_fetch_rd", mem_rd, 1'b1);
        else chk("idle_busy", busy, 1'b0);
    endtask

    task automatic start_run();
        run = 1'b1;
        tick();
    endtask

    initial begin
        logic [5:0]  r_dec;
        logic [2:0]  r_op;
        logic        r_run;

        rst       = 1'b1;
        run       = 1'b0;
        dec_op    = 6'd8;
        exec_done = 1'b0;
        pc_op     = 3'd0;
        pc_target = 12'h000;
        for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
        ram[12'h200] = 8'h6A;
        ram[12'h201] = 8'h42;
        #12;
        tick();
        do_reset();

        // Reset values
        chk_state("rst");
        chk("rst_instr", instr, 16'h0000);
        chk("rst_rd", mem_rd, 1'b0);
        chk("rst_addr", mem_addr, 12'h000);
        chk("rst_start", exec_start, 1'b0);
        chk("rst_busy", busy, 1'b0);
        tick();
        chk("idle_hold_busy", busy, 1'b0);

        // First opcode, then NEXT, CALL 0x300, RET
        start_run();
        exec_instr(6'd8, 3'd0, 12'h000, 0, 1'b1);
        exec_instr(6'd8, 3'd0, 12'h000, 1, 1'b1);
        exec_instr(6'd8, 3'd3, 12'h300, 1, 1'b1);
        exec_instr(6'd8, 3'd4, 12'h000, 2, 1'b1);
        chk("ret_pc_206", pc, 12'h206);

        // 16 nested calls, 17th overflows
        for (int i = 0; i < 16; i++) exec_instr(6'd8, 3'd3, 12'($urandom), 0, 1'b1);
        chk("sp_full", sp, 5'd16);
        exec_instr(6'd8, 3'd3, 12'h123, 0, 1'b1);
        chk("ovf_code", fault_code, 2'd2);
        for (int i = 0; i < 4; i++) begin
            exec_done = 1'b1;
            pc_op     = 3'(i + 1);
            pc_target = 12'hABC;
            tick();
            chk("halt_rd", mem_rd, 1'b0);
            chk("halt_start", exec_start, 1'b0);
        end
        exec_done = 1'b0;
        chk_state("halt_hold");
        chk("halt_busy2", busy, 1'b0);

        // Underflow, then illegal opcode
        do_reset();
        start_run();
        exec_instr(6'd8, 3'd4, 12'h000, 0, 1'b1);
        chk("unf_pc", pc, 12'h200);
        do_reset();
        start_run();
        exec_instr(6'd0, 3'd0, 12'h000, 0, 1'b1);
        repeat (3) begin
            tick();
            chk("illegal_no_start", exec_start, 1'b0);
        end

        // PC wrap-around
        do_reset();
        ram[12'hFFF] = 8'hA1;
        ram[12'h000] = 8'hB2;
        start_run();
        exec_instr(6'd8, 3'd2, 12'hFFE, 0, 1'b1);
        exec_instr(6'd8, 3'd1, 12'h000, 0, 1'b1);
        chk("skip_wrap", pc, 12'h002);
        exec_instr(6'd8, 3'd2, 12'hFFF, 0, 1'b1);
        exec_instr(6'd8, 3'd0, 12'h000, 0, 1'b1);

        // run dropped in EXEC: completes and parks in IDLE
        exec_instr(6'd8, 3'd0, 12'h000, 2, 1'b0);
        tick();
        chk("park_busy", busy, 1'b0);
        chk("park_rd", mem_rd, 1'b0);
        chk_state("park");

        // Asynchronous reset during FETCH_LO
        start_run();
        tick();
        chk("flo_before_rst", mem_rd, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        run = 1'b0;
        model_reset();
        chk_state("arst");
        chk("arst_rd", mem_rd, 1'b0);
        chk("arst_addr", mem_addr, 12'h000);
        chk("arst_instr", instr, 16'h0000);
        chk("arst_busy", busy, 1'b0);
        chk("arst_start", exec_start, 1'b0);
        #1;
        rst = 1'b0;
        tick();

        // Randomized instruction stream
        start_run();
        for (int n = 0; n < 120; n++) begin
            r_dec = ($urandom_range(0, 15) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            r_op  = 3'($urandom_range(0, 7));
            r_run = ($urandom_range(0, 4) != 0);
            exec_instr(r_dec, r_op, 12'($urandom), $urandom_range(0, 3), r_run);
            if (m_fault) begin
                tick();
                do_reset();
                start_run();
            end else if (!r_run) begin
                start_run();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
